// File: rtl/_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, bounce filter FSM, and registered level and edge pulses.
// Define DEBOUNCE_FALL_EDGE_EN to add the fall_pulse output and its register.
module _btn_debounce #(
    parameter int unsigned STABLE_CNT = 50000,
    parameter int unsigned CNT_W      = 16,
    parameter logic        RST_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse
`ifdef DEBOUNCE_FALL_EDGE_EN
    ,
    output logic fall_pulse
`endif
);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    localparam state_t           S_RESET  = RST_LEVEL ? S_HIGH : S_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             r_sync_ff1;
    logic             r_sync_ff2;
    logic             w_btn_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic             r_fall;
    logic             w_fall_nxt;
`endif

    assign w_btn_sync = r_sync_ff2;

    // Two-flop synchroniser; the only logic that ever samples the raw button.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_ff1 <= RST_LEVEL;
            r_sync_ff2 <= RST_LEVEL;
        end else begin
            r_sync_ff1 <= btn_in;
            r_sync_ff2 <= r_sync_ff1;
        end
    end

    // FSM state, stability counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RESET;
            r_cnt   <= CNT_ZERO;
            r_level <= RST_LEVEL;
            r_rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
            r_fall  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
`ifdef DEBOUNCE_FALL_EDGE_EN
            r_fall  <= w_fall_nxt;
`endif
        end
    end

    // Next-state logic; any disagreement in a WAIT state restarts the count from zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
        w_fall_nxt  = 1'b0;
`endif
        case (r_state)
            S_LOW: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_WAIT_HI;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_WAIT_HI: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_WAIT_LO;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_WAIT_LO: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
                    w_fall_nxt  = 1'b1;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = CNT_ZERO;
                w_level_nxt = RST_LEVEL;
            end
        endcase
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
`ifdef DEBOUNCE_FALL_EDGE_EN
    assign fall_pulse = r_fall;
`endif

endmodule

// File: tb/tb__btn_debounce.sv
// Directed bench for _btn_debounce (STABLE_CNT=4): vector table plus hand-written reset sequences.
// A second instance with RST_LEVEL=1 and the button held high must never move or pulse.
module tb__btn_debounce;

    logic clk;
    logic reset_n;
    logic btn0;
    logic btn1;
    logic lvl0;
    logic rise0;
    logic lvl1;
    logic rise1;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic fall0;
    logic fall1;
`endif

    int n_pass;
    int n_total;

    typedef struct {
        logic btn;
        logic lvl;
        logic rise;
        logic fall;
    } vec_t;

    vec_t tbl[$];

    _btn_debounce #(.STABLE_CNT(4), .CNT_W(3), .RST_LEVEL(1'b0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn0),
        .level_out  (lvl0),
        .rise_pulse (rise0)
`ifdef DEBOUNCE_FALL_EDGE_EN
        ,
        .fall_pulse (fall0)
`endif
    );

    _btn_debounce #(.STABLE_CNT(4), .CNT_W(3), .RST_LEVEL(1'b1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn1),
        .level_out  (lvl1),
        .rise_pulse (rise1)
`ifdef DEBOUNCE_FALL_EDGE_EN
        ,
        .fall_pulse (fall1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_hi_inst(input string tag);
        chk({tag, " hi-inst level_out"}, lvl1, 1'b1);
        chk({tag, " hi-inst rise_pulse"}, rise1, 1'b0);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk({tag, " hi-inst fall_pulse"}, fall1, 1'b0);
`endif
    endtask

    // Entered at a falling edge; drives the button, checks just after the next rising edge.
    task automatic step(input logic b, input logic el, input logic er, input logic ef, input string tag);
        btn0 = b;
        @(posedge clk);
        #1;
        chk({tag, " level_out"}, lvl0, el);
        chk({tag, " rise_pulse"}, rise0, er);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk({tag, " fall_pulse"}, fall0, ef);
`else
        chk({tag, " no rise on release"}, rise0 & ef, 1'b0);
`endif
        chk_hi_inst(tag);
        @(negedge clk);
    endtask

    task automatic push(input logic b, input logic l, input logic r, input logic f, input int n);
        for (int k = 0; k < n; k++) begin
            tbl.push_back('{btn: b, lvl: l, rise: r, fall: f});
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b1;
        btn0    = 1'b0;
        btn1    = 1'b1;

        // clean press: captured at edge 0, level/rise at edge 5, rise gone at edge 6
        push(1'b1, 1'b0, 1'b0, 1'b0, 5);
        push(1'b1, 1'b1, 1'b1, 1'b0, 1);
        push(1'b1, 1'b1, 1'b0, 1'b0, 2);
        // clean release
        push(1'b0, 1'b1, 1'b0, 1'b0, 5);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 2);
        // bounce: 1 x3, 0 x1, then steady 1 captured at edge 4 -> rise at edge 9
        push(1'b1, 1'b0, 1'b0, 1'b0, 3);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 5);
        push(1'b1, 1'b1, 1'b1, 1'b0, 1);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1);
        // short low glitch while high is rejected
        push(1'b0, 1'b1, 1'b0, 1'b0, 2);
        push(1'b1, 1'b1, 1'b0, 1'b0, 6);
        // release, then held low with no further pulses
        push(1'b0, 1'b1, 1'b0, 1'b0, 5);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4);

        #1;
        reset_n = 1'b0;
        #1;
        chk("reset level_out", lvl0, 1'b0);
        chk("reset rise_pulse", rise0, 1'b0);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk("reset fall_pulse", fall0, 1'b0);
`endif
        chk_hi_inst("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset held level_out", lvl0, 1'b0);
        chk_hi_inst("reset held");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].btn, tbl[i].lvl, tbl[i].rise, tbl[i].fall, $sformatf("vec%0d", i));
        end

        // reset mid-count: press, reset after edge 3 for two cycles, rise 5 edges after first post-release edge
        for (int e = 0; e < 4; e++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("midcnt pre e%0d", e));
        end
        reset_n = 1'b0;
        #1;
        chk("midcnt async level_out", lvl0, 1'b0);
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, "midcnt in-reset e4");
        step(1'b1, 1'b0, 1'b0, 1'b0, "midcnt in-reset e5");
        reset_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("midcnt post e%0d", e));
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, "midcnt post e5");

        // asynchronous reset mid-cycle with button high and a rise pulse in flight
        reset_n = 1'b0;
        #1;
        chk("async reset level_out", lvl0, 1'b0);
        chk("async reset rise_pulse", rise0, 1'b0);
`ifdef DEBOUNCE_FALL_EDGE_EN
        chk("async reset fall_pulse", fall0, 1'b0);
`endif
        chk_hi_inst("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, "after async reset e0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
